// File: rtl/mult_share_arb.sv
// Two-requester arbiter sharing one combinational 4x4 multiplier with registered results.
// Define MULT_PIPE_EN to add a product register stage (extra CALC2 state, one more cycle of latency).

module multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] acc_s;

    // Array multiplier: sum of AND-gated partial-product rows, one per bit of b
    always_comb begin
        acc_s = 8'd0;
        for (int i = 0; i < 4; i++) begin
            acc_s = acc_s + ({4'd0, (a & {4{b[i]}})} << i);
        end
        p = acc_s;
    end

endmodule

module mult_share_arb #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] y,
    output logic       y_valid,
    output logic       y_id,
    output logic       busy
);

`ifdef MULT_PIPE_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CALC2 = 2'd2} state_t;
    logic [7:0] prod_r;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1} state_t;
`endif

    state_t     state_r;
    logic       prio_r;
    logic       id_r;
    logic [3:0] a_r;
    logic [3:0] b_r;
    logic       win_s;
    logic [7:0] prod_s;

    multiplier u_mult (
        .a (a_r),
        .b (b_r),
        .p (prod_s)
    );

    // Winner selection: a lone request always wins, a tie goes to the priority holder
    always_comb begin
        if (req0 && req1) begin
            win_s = prio_r;
        end else if (req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Arbitration FSM with registered outputs; ack and y_valid are single-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= PRIO_INIT;
            id_r    <= 1'b0;
            a_r     <= 4'd0;
            b_r     <= 4'd0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            y       <= 8'd0;
            y_valid <= 1'b0;
            y_id    <= 1'b0;
            busy    <= 1'b0;
`ifdef MULT_PIPE_EN
            prod_r  <= 8'd0;
`endif
        end else begin
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            y_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req0 || req1) begin
                        a_r     <= win_s ? a1 : a0;
                        b_r     <= win_s ? b1 : b0;
                        id_r    <= win_s;
                        ack0    <= ~win_s;
                        ack1    <= win_s;
                        prio_r  <= ~win_s;
                        busy    <= 1'b1;
                        state_r <= CALC;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
`ifdef MULT_PIPE_EN
                CALC: begin
                    prod_r  <= prod_s;
                    busy    <= 1'b1;
                    state_r <= CALC2;
                end
                CALC2: begin
                    y       <= prod_r;
                    y_id    <= id_r;
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
`else
                CALC: begin
                    y       <= prod_s;
                    y_id    <= id_r;
                    y_valid <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
`endif
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: directed scenarios plus random traffic against a countdown model.
module tb_mult_share_arb;

`ifdef MULT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       ack0;
    logic       ack1;
    logic [7:0] y;
    logic       y_valid;
    logic       y_id;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles left in the current operation and the pending result
    int         m_rem;
    logic       m_prio;
    logic       m_pend_id;
    logic [7:0] m_pend_y;
    logic       m_ack0;
    logic       m_ack1;
    logic [7:0] m_y;
    logic       m_yv;
    logic       m_yid;
    logic       m_busy;

    mult_share_arb #(.PRIO_INIT(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .ack0    (ack0),
        .ack1    (ack1),
        .y       (y),
        .y_valid (y_valid),
        .y_id    (y_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs present before the edge
    task automatic model_edge();
        logic w;
        if (rst) begin
            m_rem = 0; m_prio = 1'b0; m_ack0 = 1'b0; m_ack1 = 1'b0;
            m_y = 8'd0; m_yv = 1'b0; m_yid = 1'b0;
        end else begin
            m_ack0 = 1'b0; m_ack1 = 1'b0; m_yv = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_y = m_pend_y; m_yid = m_pend_id; m_yv = 1'b1;
                end
            end else if (req0 || req1) begin
                w = (req0 && req1) ? m_prio : req1;
                m_pend_y  = w ? 8'(int'(a1) * int'(b1)) : 8'(int'(a0) * int'(b0));
                m_pend_id = w;
                m_ack0 = !w; m_ack1 = w;
                m_prio = !w;
                m_rem  = LAT;
            end
        end
        m_busy = (m_rem > 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ack0", {7'd0, ack0}, {7'd0, m_ack0});
        check("ack1", {7'd0, ack1}, {7'd0, m_ack1});
        check("y", y, m_y);
        check("y_valid", {7'd0, y_valid}, {7'd0, m_yv});
        check("y_id", {7'd0, y_id}, {7'd0, m_yid});
        check("busy", {7'd0, busy}, {7'd0, m_busy});
    endtask

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        m_rem = 0; m_prio = 1'b0;
        step(); step();
        rst = 1'b0;
        repeat (10) step();

        // Single requester 3x5
        req0 = 1'b1; a0 = 4'd3; b0 = 4'd5;
        step();
        check("ack0_single", {7'd0, ack0}, 8'd1);
        req0 = 1'b0;
        step(); step();
        check("y_3x5", y, 8'd15);

        // Contention with both requests held
        req0 = 1'b1; req1 = 1'b1; a0 = 4'd15; b0 = 4'd15; a1 = 4'd2; b1 = 4'd7;
        repeat (4 * (LAT + 1)) step();
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // Operands changed while busy must not affect the result
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd6;
        step();
        req1 = 1'b0; a1 = 4'd9; b1 = 4'd9;
        step(); step();
        check("y_opchange", y, 8'd24);

        // Reset during CALC discards the operation and restores priority
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd7;
        step();
        req0 = 1'b0; rst = 1'b1;
        step();
        check("y_after_rst", y, 8'd0);
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1; a0 = 4'd2; b0 = 4'd3;
        step();
        check("ack0_prio_init", {7'd0, ack0}, 8'd1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) step();

        // Random traffic including occasional resets and requests held through reset
        repeat (600) begin
            rst  = ($urandom_range(0, 39) == 0);
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            a0 = 4'($urandom); b0 = 4'($urandom);
            a1 = 4'($urandom); b1 = 4'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
